ioctl_pack_loader: RTL and testbench
====================================

Name: ioctl_pack_loader

Overview:
Parametrised HPS download engine placed between hps_io's ioctl byte stream and a core memory port such as the SRAM/SDRAM bridge or a BIOS ROM.
- Filters downloads by ioctl_index.
- Packs bytes little-endian into DATA_W-bit words with byte enables.
- Buffers words in a FIFO and writes them out over a req/ack handshake.
- Applies backpressure through ioctl_wait.
- Flushes a trailing partial word when the download ends.

Parameters:
ADDR_W, 22, memory word-address width
DATA_W, 16, memory word width; multiple of 8, 8..64
FIFO_DEPTH, 8, word FIFO entries; power of 2, >=2
INDEX_MATCH, 0, ioctl_index[7:0] value accepted; other indices ignored
BASE_ADDR, 0, word address of byte 0 of the download

Ports:
clk_sys  in  1  system clock
reset_n  in  1  synchronous active-low reset
ioctl_download  in  1  download active
ioctl_index  in  16  download target index
ioctl_wr  in  1  byte strobe, one cycle
ioctl_addr  in  25  byte address within download
ioctl_dout  in  8  byte data
ioctl_wait  out  1  backpressure to hps_io
mem_req  out  1  write request, held until ack
mem_ack  in  1  one-cycle write accept
mem_addr  out  ADDR_W  word address
mem_din  out  DATA_W  write data
mem_be  out  DATA_W/8  byte enables
busy  out  1  download accepted and not yet fully written
done  out  1  one-cycle pulse after the final write is acked

Behaviour:
Interface:
- One clock, clk_sys. reset_n is synchronous, active-low.
- While reset_n=0: every output is 0, FIFO is emptied, packer is cleared, FSM is in IDLE.
- Reset mid-download abandons all pending data; no done pulse is produced.

Byte lanes:
- B = DATA_W/8.
- lane = ioctl_addr mod B.
- word address = BASE_ADDR + ioctl_addr/B, truncated to ADDR_W.

FSM states:
- IDLE: when ioctl_download=1 and ioctl_index[7:0]=INDEX_MATCH, go to LOAD and set busy=1. A non-matching index stays in IDLE, ignores ioctl_wr, and keeps ioctl_wait=0.
- LOAD: each ioctl_wr writes the byte into pack register lane `lane` and sets be[lane].
  - Word commit happens when lane = B-1, or when the incoming byte's word address differs from the held word (non-sequential address). In the second case the held partial word is committed first, with its be; the new byte then starts a fresh word.
  - Committing means pushing {addr, data, be} into the FIFO. The pack register clears the same cycle.
  - On the falling edge of ioctl_download: go to FLUSH.
- FLUSH: if be≠0, push the partial word, waiting for a free FIFO slot. Then go to DRAIN.
- DRAIN: wait until the FIFO is empty and no request is outstanding. Then pulse done for 1 cycle, clear busy, and return to IDLE.

Backpressure:
- ioctl_wait=1 whenever FIFO count >= FIFO_DEPTH-1. This leaves one slot for a byte already in flight.
- A byte write arriving when a commit is needed and the FIFO is full must not be lost. It is held in a 1-entry skid until a slot frees. Bench checks that no byte is ever dropped.

Memory side:
- When FIFO is non-empty and mem_req=0, present the head and assert mem_req on the next cycle.
- Keep mem_addr, mem_din and mem_be stable until mem_ack. Pop on mem_ack.
- mem_req may re-assert the cycle after ack; sustained throughput is 1 word per 2 cycles minimum.
- mem_ack while mem_req=0 is ignored.

Simultaneous events:
- A push and a pop in the same cycle leave the count unchanged.
- ioctl_wr in the same cycle as download falling: the byte is accepted before FLUSH.

Optional Feature:
Macro IOCTL_PACK_LOADER_CKSUM_EN.
- Defined: adds output cksum[15:0], the running 16-bit modular sum of all accepted bytes.
  - Cleared on IDLE→LOAD.
  - Frozen from FLUSH onward.
  - Valid when done pulses.
- Undefined: the port and the adder are absent. Behaviour is otherwise identical.

Test Plan:
1. DATA_W=16, BASE_ADDR=0x100, 4 bytes 11,22,33,44 at addr 0..3, mem_ack 1 cycle after req -> writes (0x100, 0x2211, be=11), (0x101, 0x4433, be=11); done one cycle after the 2nd ack.
2. 3 bytes AA,BB,CC at addr 0..2, then download falls -> writes 0xBBAA be=11, then 0x00CC be=01; busy drops together with done.
3. FIFO_DEPTH=4, mem_ack held low for 50 cycles, 16 bytes streamed -> ioctl_wait=1 once count reaches 3; after acks resume, all 8 words are written in order with no loss.
4. ioctl_index=5 with INDEX_MATCH=0 -> no mem_req, busy=0, ioctl_wait=0, no done.
5. Byte at addr 0 followed by byte at addr 8 (DATA_W=16) -> write (BASE, be=01), then (BASE+4, be=01).
6. reset_n low for 1 cycle during LOAD with 2 words queued -> all outputs 0 the next cycle; no further mem_req and no done. With IOCTL_PACK_LOADER_CKSUM_EN, bytes 01,02,FF -> cksum=0x0102 at done.

Source files
------------

// File: rtl/ioctl_pack_loader_if.sv
// ioctl_pack_loader_if
//   Bundles the hps_io ioctl byte stream and the memory write port of
//   ioctl_pack_loader.
//   master : the hps_io / memory environment side (drives ioctl_*, mem_ack)
//   slave  : the loader side (drives ioctl_wait, mem_req/addr/din/be)
// Signals:
//   ioctl_download, ioctl_index[15:0], ioctl_wr, ioctl_addr[24:0],
//   ioctl_dout[7:0], ioctl_wait, mem_req, mem_ack, mem_addr[ADDR_W-1:0],
//   mem_din[DATA_W-1:0], mem_be[DATA_W/8-1:0]
interface ioctl_pack_loader_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
);
  logic                  ioctl_download;
  logic [15:0]           ioctl_index;
  logic                  ioctl_wr;
  logic [24:0]           ioctl_addr;
  logic [7:0]            ioctl_dout;
  logic                  ioctl_wait;
  logic                  mem_req;
  logic                  mem_ack;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_din;
  logic [DATA_W/8-1:0]   mem_be;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    input  ioctl_wait, mem_req, mem_addr, mem_din, mem_be
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    output ioctl_wait, mem_req, mem_addr, mem_din, mem_be
  );
endinterface

// File: rtl/ioctl_pack_loader.sv
// ioctl_pack_loader
//   HPS download engine: accepts the ioctl byte stream for one ioctl_index,
//   packs bytes little-endian into DATA_W-bit words with byte enables, queues
//   them in a word FIFO and writes them to memory over a req/ack handshake.
//   A trailing partial word is flushed when the download ends.
// Ports:
//   clk_sys  - system clock
//   reset_n  - synchronous active-low reset
//   bus      - ioctl_pack_loader_if.slave (ioctl stream in, memory write out)
//   busy     - download accepted and not yet fully written
//   done     - one-cycle pulse after the final write is acknowledged
//   cksum    - 16-bit running byte sum (only with IOCTL_PACK_LOADER_CKSUM_EN)
// Optional feature macro: IOCTL_PACK_LOADER_CKSUM_EN
module ioctl_pack_loader #(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int INDEX_MATCH = 0,
  parameter int BASE_ADDR   = 0
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  ioctl_pack_loader_if.slave bus,
  output logic               busy,
  output logic               done
`ifdef IOCTL_PACK_LOADER_CKSUM_EN
  ,
  output logic [15:0]        cksum
`endif
);
  localparam int B  = DATA_W / 8;
  localparam int LW = (B > 1) ? $clog2(B) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] pk_addr_q, pk_addr_d;
  logic [DATA_W-1:0] pk_data_q, pk_data_d;
  logic [B-1:0]      pk_be_q, pk_be_d;

  logic              skid_vld_q, skid_vld_d;
  logic [24:0]       skid_addr_q, skid_addr_d;
  logic [7:0]        skid_dout_q, skid_dout_d;

  logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] f_data [FIFO_DEPTH];
  logic [B-1:0]      f_be   [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [B-1:0]      mem_be_q, mem_be_d;

  logic              wr_take, src_vld, pk_open, fifo_full, jump, last;
  logic [24:0]       src_addr;
  logic [7:0]        src_dout;
  logic [LW-1:0]     src_lane;
  logic [ADDR_W-1:0] src_waddr;
  logic [B-1:0]      lane_be;
  logic [DATA_W-1:0] lane_data, lane_mask, pk_base;
  logic              push, pop, consumed, flush_push;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic [B-1:0]      push_be;
  logic              unused_idx;

  assign unused_idx = ^bus.ioctl_index[15:8];

  // Byte source: a byte parked in the skid has priority over a new strobe.
  assign wr_take   = bus.ioctl_wr && (state_q == LOAD);
  assign src_vld   = skid_vld_q || wr_take;
  assign src_addr  = skid_vld_q ? skid_addr_q : bus.ioctl_addr;
  assign src_dout  = skid_vld_q ? skid_dout_q : bus.ioctl_dout;
  assign src_lane  = LW'(32'(src_addr) % 32'(B));
  assign src_waddr = ADDR_W'(32'(BASE_ADDR) + 32'(src_addr) / 32'(B));
  assign lane_be   = B'(1) << src_lane;
  assign lane_data = DATA_W'(src_dout) << {src_lane, 3'b000};
  assign lane_mask = DATA_W'(8'hFF) << {src_lane, 3'b000};
  assign pk_open   = |pk_be_q;
  assign pk_base   = pk_open ? pk_data_q : '0;
  assign fifo_full = (cnt_q == CW'(FIFO_DEPTH));
  assign jump      = pk_open && (src_waddr != pk_addr_q);
  assign last      = (src_lane == LW'(B - 1));
  assign pop       = mem_req_q && bus.mem_ack;

  // Packer / commit. A jump whose byte also lands on the top lane needs two
  // pushes; the held word goes first and the byte stays in the skid for the
  // next cycle.
  always_comb begin
    pk_addr_d  = pk_addr_q;
    pk_data_d  = pk_data_q;
    pk_be_d    = pk_be_q;
    push       = 1'b0;
    push_addr  = pk_addr_q;
    push_data  = pk_data_q;
    push_be    = pk_be_q;
    consumed   = 1'b0;
    flush_push = 1'b0;
    if (src_vld) begin
      if (jump) begin
        if (!fifo_full) begin
          push     = 1'b1;
          consumed = !last;
          pk_addr_d = src_waddr;
          pk_data_d = last ? '0 : lane_data;
          pk_be_d   = last ? '0 : lane_be;
        end
      end else if (last) begin
        if (!fifo_full) begin
          push      = 1'b1;
          consumed  = 1'b1;
          push_addr = src_waddr;
          push_data = (pk_base & ~lane_mask) | lane_data;
          push_be   = pk_be_q | lane_be;
          pk_data_d = '0;
          pk_be_d   = '0;
        end
      end else begin
        consumed  = 1'b1;
        pk_addr_d = src_waddr;
        pk_data_d = (pk_base & ~lane_mask) | lane_data;
        pk_be_d   = pk_be_q | lane_be;
      end
    end else if (state_q == FLUSH && pk_open && !fifo_full) begin
      push       = 1'b1;
      flush_push = 1'b1;
      pk_data_d  = '0;
      pk_be_d    = '0;
    end
  end

  // Skid: captures a strobe that cannot be consumed this cycle. Only one
  // byte can wait; ioctl_wait is raised while it is occupied.
  always_comb begin
    skid_vld_d  = skid_vld_q;
    skid_addr_d = skid_addr_q;
    skid_dout_d = skid_dout_q;
    if (skid_vld_q && consumed) skid_vld_d = 1'b0;
    if (wr_take && (skid_vld_q ? consumed : !consumed)) begin
      skid_vld_d  = 1'b1;
      skid_addr_d = bus.ioctl_addr;
      skid_dout_d = bus.ioctl_dout;
    end
  end

  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  // Memory side: the head is latched into the output registers when idle and
  // held there until the ack pops it.
  always_comb begin
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_be_d   = mem_be_q;
    if (pop) begin
      mem_req_d = 1'b0;
    end else if (!mem_req_q && cnt_q != '0) begin
      mem_req_d  = 1'b1;
      mem_addr_d = f_addr[rp_q];
      mem_din_d  = f_data[rp_q];
      mem_be_d   = f_be[rp_q];
    end
  end

  // FSM state register
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:  if (bus.ioctl_download && bus.ioctl_index[7:0] == 8'(INDEX_MATCH)) state_d = LOAD;
      LOAD:  if (!bus.ioctl_download) state_d = FLUSH;
      FLUSH: if (!skid_vld_q && (!pk_open || flush_push)) state_d = DRAIN;
      DRAIN: if (cnt_d == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
             end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy           = (state_q != IDLE);
    done           = done_q;
    bus.ioctl_wait = (cnt_q >= CW'(FIFO_DEPTH - 1)) || skid_vld_q;
    bus.mem_req    = mem_req_q;
    bus.mem_addr   = mem_addr_q;
    bus.mem_din    = mem_din_q;
    bus.mem_be     = mem_be_q;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      pk_be_q    <= '0;
      skid_vld_q <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_be_q   <= '0;
    end else begin
      pk_be_q    <= pk_be_d;
      skid_vld_q <= skid_vld_d;
      wp_q       <= wp_q + PW'(push);
      rp_q       <= rp_q + PW'(pop);
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_be_q   <= mem_be_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    pk_addr_q   <= pk_addr_d;
    pk_data_q   <= pk_data_d;
    skid_addr_q <= skid_addr_d;
    skid_dout_q <= skid_dout_d;
    if (push) begin
      f_addr[wp_q] <= push_addr;
      f_data[wp_q] <= push_data;
      f_be[wp_q]   <= push_be;
    end
  end

`ifdef IOCTL_PACK_LOADER_CKSUM_EN
  logic [15:0] cks_q;
  always_ff @(posedge clk_sys) begin
    if (!reset_n)                                cks_q <= '0;
    else if (state_q == IDLE && state_d == LOAD) cks_q <= '0;
    else if (wr_take)                            cks_q <= cks_q + 16'(bus.ioctl_dout);
  end
  assign cksum = cks_q;
`endif
endmodule

// File: tb/tb_ioctl_pack_loader.sv
module tb_ioctl_pack_loader;
  localparam int AW = 22;
  localparam int DW = 16;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic busy, done;
`ifdef IOCTL_PACK_LOADER_CKSUM_EN
  logic [15:0] cksum;
`endif

  ioctl_pack_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ioctl_pack_loader #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .INDEX_MATCH(0), .BASE_ADDR(32'h100)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus(bus),
    .busy(busy),
    .done(done)
`ifdef IOCTL_PACK_LOADER_CKSUM_EN
    ,
    .cksum(cksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks one cycle after it first sees mem_req, logs writes.
  logic [AW-1:0] lw_addr[$];
  logic [DW-1:0] lw_din[$];
  logic [1:0]    lw_be[$];
  logic          ack_hold = 1'b0;
  int            last_ack_cyc = 0;
  initial begin
    logic seen;
    seen = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (bus.mem_ack) bus.mem_ack = 1'b0;
      else if (bus.mem_req && seen && !ack_hold) begin
        bus.mem_ack = 1'b1;
        lw_addr.push_back(bus.mem_addr);
        lw_din.push_back(bus.mem_din);
        lw_be.push_back(bus.mem_be);
        last_ack_cyc = cyc;
      end
      seen = bus.mem_req;
    end
  end

  // Output monitor
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          req_cnt  = 0;
  logic        busy_prev = 1'b0, busy_at_done = 1'b0, busy_before_done = 1'b0;
  logic [15:0] cks_at_done = 16'h0;
  initial begin
    forever begin
      @(negedge clk_sys);
      if (bus.mem_req) req_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc         = cyc;
        busy_at_done     = busy;
        busy_before_done = busy_prev;
`ifdef IOCTL_PACK_LOADER_CKSUM_EN
        cks_at_done      = cksum;
`endif
      end
      busy_prev = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic start_dl(input logic [15:0] idx);
    @(negedge clk_sys);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = idx;
    @(negedge clk_sys);
  endtask

  // Send one byte; with fin=1 the download falls in the same cycle.
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input logic fin);
    @(negedge clk_sys);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    if (fin) bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0, k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    chk(tag, 64'(done_cnt != n0), 64'd1);
  endtask

  task automatic chk_wr(input string tag, input int k, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [1:0] be);
    logic [63:0] ga, gd, gb;
    ga = (k < lw_addr.size()) ? 64'(lw_addr[k]) : 64'hBAD0_0000_0000;
    gd = (k < lw_din.size())  ? 64'(lw_din[k])  : 64'hBAD0_0000_0000;
    gb = (k < lw_be.size())   ? 64'(lw_be[k])   : 64'hBAD0_0000_0000;
    chk({tag, "_addr"}, ga, 64'(a));
    chk({tag, "_din"},  gd, 64'(d));
    chk({tag, "_be"},   gb, 64'(be));
  endtask

  initial begin
    int b0, d0, r0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 16'h0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.mem_ack        = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_sys);
    chk("rst_req",  64'(bus.mem_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wait", 64'(bus.ioctl_wait), 64'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // 1: four bytes, last strobe coincides with download falling
    b0 = lw_addr.size(); d0 = done_cnt;
    start_dl(16'h0000);
    send_byte(25'd0, 8'h11, 1'b0);
    send_byte(25'd1, 8'h22, 1'b0);
    send_byte(25'd2, 8'h33, 1'b0);
    send_byte(25'd3, 8'h44, 1'b1);
    wait_done("t1_done", 200);
    chk("t1_nwr", 64'(lw_addr.size() - b0), 64'd2);
    chk_wr("t1_w0", b0,     22'h100, 16'h2211, 2'b11);
    chk_wr("t1_w1", b0 + 1, 22'h101, 16'h4433, 2'b11);
    chk("t1_done_lat", 64'(done_cyc - last_ack_cyc), 64'd1);
    chk("t1_ndone", 64'(done_cnt - d0), 64'd1);

    // 2: trailing partial word flushed; busy falls with done
    b0 = lw_addr.size();
    start_dl(16'h0000);
    send_byte(25'd0, 8'hAA, 1'b0);
    send_byte(25'd1, 8'hBB, 1'b0);
    send_byte(25'd2, 8'hCC, 1'b1);
    wait_done("t2_done", 200);
    chk("t2_nwr", 64'(lw_addr.size() - b0), 64'd2);
    chk_wr("t2_w0", b0,     22'h100, 16'hBBAA, 2'b11);
    chk_wr("t2_w1", b0 + 1, 22'h101, 16'h00CC, 2'b01);
    chk("t2_busy_at_done", 64'(busy_at_done), 64'd0);
    chk("t2_busy_before",  64'(busy_before_done), 64'd1);

    // 3: backpressure with acks stalled; 16 bytes, none lost
    b0 = lw_addr.size();
    ack_hold = 1'b1;
    start_dl(16'h0000);
    for (int i = 0; i < 10; i++) begin
      send_byte(25'(i), 8'(8'h40 + i), 1'b0);
      if (i == 4) chk("t3_wait_cnt2", 64'(bus.ioctl_wait), 64'd0);
      if (i == 5) chk("t3_wait_cnt3", 64'(bus.ioctl_wait), 64'd1);
      if (i == 9) chk("t3_wait_skid", 64'(bus.ioctl_wait), 64'd1);
    end
    repeat (30) @(negedge clk_sys);
    chk("t3_no_wr_in_hold", 64'(lw_addr.size() - b0), 64'd0);
    ack_hold = 1'b0;
    for (int i = 10; i < 16; i++) begin
      int k;
      k = 0;
      while (bus.ioctl_wait && k < 200) begin
        @(negedge clk_sys);
        k++;
      end
      if (k >= 200) chk("t3_wait_stuck", 64'd1, 64'd0);
      send_byte(25'(i), 8'(8'h40 + i), (i == 15));
    end
    wait_done("t3_done", 400);
    chk("t3_nwr", 64'(lw_addr.size() - b0), 64'd8);
    for (int k = 0; k < 8; k++)
      chk_wr("t3_w", b0 + k, 22'(32'h100 + k),
             {8'(8'h41 + 2 * k), 8'(8'h40 + 2 * k)}, 2'b11);

    // 4: non-matching index is ignored
    r0 = req_cnt; d0 = done_cnt; b0 = lw_addr.size();
    start_dl(16'h0005);
    send_byte(25'd0, 8'h12, 1'b0);
    chk("t4_busy", 64'(busy), 64'd0);
    send_byte(25'd1, 8'h34, 1'b0);
    chk("t4_wait", 64'(bus.ioctl_wait), 64'd0);
    send_byte(25'd2, 8'h56, 1'b1);
    repeat (10) @(negedge clk_sys);
    chk("t4_req", 64'(req_cnt - r0), 64'd0);
    chk("t4_done", 64'(done_cnt - d0), 64'd0);
    chk("t4_nwr", 64'(lw_addr.size() - b0), 64'd0);

    // 5: non-sequential address commits the held partial word
    b0 = lw_addr.size();
    start_dl(16'h0000);
    send_byte(25'd0, 8'h5A, 1'b0);
    send_byte(25'd8, 8'hA5, 1'b1);
    wait_done("t5_done", 200);
    chk("t5_nwr", 64'(lw_addr.size() - b0), 64'd2);
    chk_wr("t5_w0", b0,     22'h100, 16'h005A, 2'b01);
    chk_wr("t5_w1", b0 + 1, 22'h104, 16'h00A5, 2'b01);

    // 6: reset during LOAD with two words queued
    b0 = lw_addr.size(); d0 = done_cnt;
    ack_hold = 1'b1;
    start_dl(16'h0000);
    send_byte(25'd0, 8'h01, 1'b0);
    send_byte(25'd1, 8'h02, 1'b0);
    send_byte(25'd2, 8'h03, 1'b0);
    send_byte(25'd3, 8'h04, 1'b0);
    chk("t6_req_before", 64'(bus.mem_req), 64'd1);
    reset_n = 1'b0;
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    chk("t6_req",  64'(bus.mem_req), 64'd0);
    chk("t6_addr", 64'(bus.mem_addr), 64'd0);
    chk("t6_din",  64'(bus.mem_din), 64'd0);
    chk("t6_be",   64'(bus.mem_be), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_wait", 64'(bus.ioctl_wait), 64'd0);
    r0 = req_cnt;
    ack_hold = 1'b0;
    repeat (30) @(negedge clk_sys);
    chk("t6_req_after", 64'(req_cnt - r0), 64'd0);
    chk("t6_done", 64'(done_cnt - d0), 64'd0);
    chk("t6_nwr", 64'(lw_addr.size() - b0), 64'd0);

    // 7: checksum download 01,02,FF
    b0 = lw_addr.size();
    start_dl(16'h0000);
    send_byte(25'd0, 8'h01, 1'b0);
    send_byte(25'd1, 8'h02, 1'b0);
    send_byte(25'd2, 8'hFF, 1'b1);
    wait_done("t7_done", 200);
    chk_wr("t7_w0", b0,     22'h100, 16'h0201, 2'b11);
    chk_wr("t7_w1", b0 + 1, 22'h101, 16'h00FF, 2'b01);
`ifdef IOCTL_PACK_LOADER_CKSUM_EN
    chk("t7_cksum", 64'(cks_at_done), 64'h0102);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
